instr_fetch_unit: RTL and testbench

//  Instruction-fetch stage of the multicycle RV32 core. Serves fetch requests from the core control
//  FSM (raised while in FETCH) by running a req/gnt/rvalid transaction on the instruction-memory

---
 rtl/instr_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch stage of the multicycle RV32 core.
// Runs one req/gnt/rvalid transaction per fetch and reports faults.
module instr_fetch_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req_i,
    input  logic [31:0] fetch_pc_i,
    input  logic        flush_i,
    output logic        fetch_done_o,
    output logic [31:0] instr_o,
    output logic [31:0] fetch_pc_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_err_i
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DONE  = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_MIS  = 2'd1;
    localparam logic [1:0] C_BUS  = 2'd2;
    localparam logic [1:0] C_TMO  = 2'd3;

    logic [2:0]    state, state_n;
    logic [31:0]   pc, pc_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic          drain, drain_n;
    logic          req, req_n;
    logic          fin;
    logic [1:0]    cause_n;
    logic [31:0]   data_n;
    logic          expired;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign expired = (cnt == CNT_LAST);

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cnt;
        drain_n = drain;
        req_n   = req;
        fin     = 1'b0;
        cause_n = C_NONE;
        data_n  = NOP_INSTR;
        case (state)
            IDLE: begin
                cnt_n   = '0;
                drain_n = 1'b0;
                if (fetch_req_i && !flush_i) begin
                    pc_n = fetch_pc_i;
                    if (fetch_pc_i[1:0] != 2'b00) begin
                        fin     = 1'b1;
                        cause_n = C_MIS;
                    end else begin
                        state_n = REQ;
                        req_n   = 1'b1;
                    end
                end
            end
            REQ: begin
                cnt_n = cnt_inc;
                if (flush_i) begin
                    req_n = 1'b0;
                    if (imem_gnt_i && !imem_rvalid_i)
                        state_n = DRAIN;
                    else
                        state_n = IDLE;
                end else if (imem_gnt_i && imem_rvalid_i) begin
                    fin = 1'b1;
                    if (imem_err_i) cause_n = C_BUS;
                    else data_n = imem_rdata_i;
                end else if (expired) begin
                    fin     = 1'b1;
                    cause_n = C_TMO;
                    drain_n = imem_gnt_i;
                end else if (imem_gnt_i) begin
                    state_n = WAIT;
                    req_n   = 1'b0;
                end
            end
            WAIT: begin
                cnt_n = cnt_inc;
                if (flush_i) begin
                    state_n = imem_rvalid_i ? IDLE : DRAIN;
                end else if (imem_rvalid_i) begin
                    fin = 1'b1;
                    if (imem_err_i) cause_n = C_BUS;
                    else data_n = imem_rdata_i;
                end else if (expired) begin
                    fin     = 1'b1;
                    cause_n = C_TMO;
                    drain_n = 1'b1;
                end
            end
            DONE: begin
                state_n = drain ? DRAIN : IDLE;
                drain_n = 1'b0;
            end
            DRAIN: begin
                if (imem_rvalid_i) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                req_n   = 1'b0;
            end
        endcase
        // Completion always passes through DONE and drops the request.
        if (fin) begin
            state_n = DONE;
            req_n   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= '0;
            cnt           <= '0;
            drain         <= 1'b0;
            req           <= 1'b0;
            fetch_done_o  <= 1'b0;
            instr_o       <= NOP_INSTR;
            fetch_pc_o    <= '0;
            fault_o       <= 1'b0;
            fault_cause_o <= C_NONE;
        end else begin
            state        <= state_n;
            pc           <= pc_n;
            cnt          <= cnt_n;
            drain        <= drain_n;
            req          <= req_n;
            fetch_done_o <= fin;
            if (fin) begin
                instr_o       <= data_n;
                fetch_pc_o    <= pc_n;
                fault_o       <= (cause_n != C_NONE);
                fault_cause_o <= cause_n;
            end
        end
    end

    assign imem_req_o  = req;
    assign imem_addr_o = pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: dut_a uses the default timeout,
// dut_b a short timeout; both share the memory-side stimulus.
module tb_instr_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk;
    logic        reset;
    logic        req_a, req_b;
    logic [31:0] pc_in;
    logic        flush;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;

    logic        done_a, fault_a, mreq_a;
    logic [31:0] instr_a, fpc_a, addr_a;
    logic [1:0]  cause_a;
    logic        done_b, fault_b, mreq_b;
    logic [31:0] instr_b, fpc_b, addr_b;
    logic [1:0]  cause_b;

    int tests = 0;
    int fails = 0;

    instr_fetch_unit dut_a (
        .clk(clk), .reset(reset),
        .fetch_req_i(req_a), .fetch_pc_i(pc_in), .flush_i(flush),
        .fetch_done_o(done_a), .instr_o(instr_a), .fetch_pc_o(fpc_a),
        .fault_o(fault_a), .fault_cause_o(cause_a),
        .imem_req_o(mreq_a), .imem_addr_o(addr_a),
        .imem_gnt_i(gnt), .imem_rvalid_i(rvalid),
        .imem_rdata_i(rdata), .imem_err_i(err)
    );

    instr_fetch_unit #(.TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .reset(reset),
        .fetch_req_i(req_b), .fetch_pc_i(pc_in), .flush_i(flush),
        .fetch_done_o(done_b), .instr_o(instr_b), .fetch_pc_o(fpc_b),
        .fault_o(fault_b), .fault_cause_o(cause_b),
        .imem_req_o(mreq_b), .imem_addr_o(addr_b),
        .imem_gnt_i(gnt), .imem_rvalid_i(rvalid),
        .imem_rdata_i(rdata), .imem_err_i(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests++;
        if ({done_a, mreq_a, fault_a, cause_a} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctl_a: got %b want 00000", {done_a, mreq_a, fault_a, cause_a});
        end
        tests++;
        if ({instr_a, fpc_a, addr_a} !== {NOP, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL reset_data_a: got %h %h %h want %h 0 0", instr_a, fpc_a, addr_a, NOP);
        end
        tests++;
        if ({done_b, mreq_b, fault_b, cause_b, instr_b} !== {5'b0, NOP}) begin
            fails++;
            $display("FAIL reset_b: got %b %h", {done_b, mreq_b, fault_b, cause_b}, instr_b);
        end
    endtask

    task automatic test_basic();
        pc_in = 32'h100;
        req_a = 1'b1;
        step();
        tests++;
        if ({mreq_a, done_a, addr_a} !== {2'b10, 32'h100}) begin
            fails++;
            $display("FAIL basic_c1: got req=%b done=%b addr=%h want 1 0 100", mreq_a, done_a, addr_a);
        end
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        tests++;
        if ({mreq_a, done_a} !== 2'b00) begin
            fails++;
            $display("FAIL basic_c2: got req=%b done=%b want 0 0", mreq_a, done_a);
        end
        rvalid = 1'b1;
        rdata = 32'h00500093;
        step();
        rvalid = 1'b0;
        req_a = 1'b0;
        tests++;
        if ({done_a, instr_a, fpc_a, fault_a} !== {1'b1, 32'h00500093, 32'h100, 1'b0}) begin
            fails++;
            $display("FAIL basic_c3: got done=%b instr=%h pc=%h fault=%b want 1 00500093 100 0", done_a, instr_a, fpc_a, fault_a);
        end
        step();
        tests++;
        if ({done_a, instr_a} !== {1'b0, 32'h00500093}) begin
            fails++;
            $display("FAIL basic_c4: got done=%b instr=%h want 0 00500093", done_a, instr_a);
        end
    endtask

    task automatic test_misaligned();
        pc_in = 32'h102;
        req_a = 1'b1;
        step();
        req_a = 1'b0;
        tests++;
        if ({done_a, mreq_a, fault_a, cause_a, instr_a, fpc_a} !== {3'b101, 2'd1, NOP, 32'h102}) begin
            fails++;
            $display("FAIL misalign_c1: got done=%b req=%b fault=%b cause=%0d instr=%h pc=%h want 1 0 1 1 %h 102", done_a, mreq_a, fault_a, cause_a, instr_a, fpc_a, NOP);
        end
        step();
        tests++;
        if ({done_a, mreq_a} !== 2'b00) begin
            fails++;
            $display("FAIL misalign_c2: got done=%b req=%b want 0 0", done_a, mreq_a);
        end
    endtask

    task automatic test_gnt_stall();
        int bad = 0;
        int pulses = 0;
        pc_in = 32'h200;
        req_a = 1'b1;
        step();
        for (int c = 1; c <= 10; c++) begin
            if (!(mreq_a === 1'b1 && addr_a === 32'h200)) bad++;
            if (done_a === 1'b1) pulses++;
            step();
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL stall_hold: got %0d unstable cycles want 0", bad);
        end
        gnt = 1'b1;
        rvalid = 1'b1;
        rdata = 32'h00A00113;
        step();
        gnt = 1'b0;
        rvalid = 1'b0;
        req_a = 1'b0;
        tests++;
        if ({done_a, instr_a, fpc_a} !== {1'b1, 32'h00A00113, 32'h200}) begin
            fails++;
            $display("FAIL stall_done: got done=%b instr=%h pc=%h want 1 00a00113 200", done_a, instr_a, fpc_a);
        end
        if (done_a === 1'b1) pulses++;
        step();
        if (done_a === 1'b1) pulses++;
        tests++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL stall_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_flush();
        int bad = 0;
        pc_in = 32'h500;
        req_a = 1'b1;
        step();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        flush = 1'b1;
        req_a = 1'b0;
        step();
        flush = 1'b0;
        for (int c = 3; c <= 7; c++) begin
            if (done_a !== 1'b0 || mreq_a !== 1'b0) bad++;
            rvalid = (c == 5);
            rdata = 32'hDEADBEEF;
            step();
        end
        rvalid = 1'b0;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL flush_wait_nodone: got %0d bad cycles want 0", bad);
        end
        tests++;
        if ({instr_a, fault_a} !== {32'h00A00113, 1'b0}) begin
            fails++;
            $display("FAIL flush_wait_hold: got instr=%h fault=%b want 00a00113 0", instr_a, fault_a);
        end
        pc_in = 32'h600;
        req_a = 1'b1;
        step();
        tests++;
        if ({mreq_a, addr_a} !== {1'b1, 32'h600}) begin
            fails++;
            $display("FAIL flush_req_start: got req=%b addr=%h want 1 600", mreq_a, addr_a);
        end
        flush = 1'b1;
        req_a = 1'b0;
        step();
        flush = 1'b0;
        tests++;
        if ({mreq_a, done_a} !== 2'b00) begin
            fails++;
            $display("FAIL flush_req_drop: got req=%b done=%b want 0 0", mreq_a, done_a);
        end
        step();
        tests++;
        if ({mreq_a, done_a, instr_a} !== {2'b00, 32'h00A00113}) begin
            fails++;
            $display("FAIL flush_req_idle: got req=%b done=%b instr=%h", mreq_a, done_a, instr_a);
        end
    endtask

    task automatic test_bus_error();
        pc_in = 32'h300;
        req_a = 1'b1;
        step();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        rvalid = 1'b1;
        err = 1'b1;
        rdata = 32'h11111111;
        step();
        rvalid = 1'b0;
        err = 1'b0;
        req_a = 1'b0;
        tests++;
        if ({done_a, fault_a, cause_a, instr_a, fpc_a} !== {2'b11, 2'd2, NOP, 32'h300}) begin
            fails++;
            $display("FAIL bus_error: got done=%b fault=%b cause=%0d instr=%h pc=%h want 1 1 2 %h 300", done_a, fault_a, cause_a, instr_a, fpc_a, NOP);
        end
        step();
    endtask

    task automatic test_timeout();
        int bad = 0;
        pc_in = 32'h400;
        req_b = 1'b1;
        step();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        for (int c = 2; c <= 8; c++) begin
            if (done_b !== 1'b0) bad++;
            step();
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL timeout_early: got %0d early pulses want 0", bad);
        end
        tests++;
        if ({done_b, fault_b, cause_b, instr_b, fpc_b} !== {2'b11, 2'd3, NOP, 32'h400}) begin
            fails++;
            $display("FAIL timeout_done: got done=%b fault=%b cause=%0d instr=%h pc=%h want 1 1 3 %h 400", done_b, fault_b, cause_b, instr_b, fpc_b, NOP);
        end
        req_b = 1'b0;
        step();
        pc_in = 32'h404;
        req_b = 1'b1;
        step();
        bad = 0;
        if (mreq_b !== 1'b0) bad++;
        step();
        if (mreq_b !== 1'b0) bad++;
        rvalid = 1'b1;
        rdata = 32'hDEADBEEF;
        step();
        rvalid = 1'b0;
        if (done_b !== 1'b0 || instr_b !== NOP) bad++;
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL timeout_drain: got %0d bad cycles want 0", bad);
        end
        step();
        tests++;
        if ({mreq_b, addr_b} !== {1'b1, 32'h404}) begin
            fails++;
            $display("FAIL timeout_next_req: got req=%b addr=%h want 1 404", mreq_b, addr_b);
        end
        gnt = 1'b1;
        rvalid = 1'b1;
        rdata = 32'h00100073;
        step();
        gnt = 1'b0;
        rvalid = 1'b0;
        req_b = 1'b0;
        tests++;
        if ({done_b, fault_b, cause_b, instr_b, fpc_b} !== {2'b10, 2'd0, 32'h00100073, 32'h404}) begin
            fails++;
            $display("FAIL timeout_next_done: got done=%b fault=%b cause=%0d instr=%h pc=%h want 1 0 0 00100073 404", done_b, fault_b, cause_b, instr_b, fpc_b);
        end
        step();
    endtask

    task automatic test_reset_mid();
        pc_in = 32'h700;
        req_a = 1'b1;
        step();
        gnt = 1'b1;
        step();
        gnt = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({done_a, mreq_a, fault_a, cause_a, instr_a, fpc_a, addr_a} !== {5'b0, NOP, 32'h0, 32'h0}) begin
            fails++;
            $display("FAIL reset_mid: got done=%b req=%b fault=%b cause=%0d instr=%h pc=%h addr=%h", done_a, mreq_a, fault_a, cause_a, instr_a, fpc_a, addr_a);
        end
        step();
        reset = 1'b0;
        req_a = 1'b0;
        rvalid = 1'b1;
        rdata = 32'h12345678;
        step();
        rvalid = 1'b0;
        tests++;
        if ({done_a, mreq_a, instr_a} !== {2'b00, NOP}) begin
            fails++;
            $display("FAIL reset_stray_c1: got done=%b req=%b instr=%h", done_a, mreq_a, instr_a);
        end
        step();
        tests++;
        if ({done_a, mreq_a, instr_a} !== {2'b00, NOP}) begin
            fails++;
            $display("FAIL reset_stray_c2: got done=%b req=%b instr=%h", done_a, mreq_a, instr_a);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_a = 1'b0;
        req_b = 1'b0;
        pc_in = '0;
        flush = 1'b0;
        gnt = 1'b0;
        rvalid = 1'b0;
        err = 1'b0;
        rdata = '0;
        #3;
        test_reset();
        step();
        step();
        reset = 1'b0;
        step();
        test_basic();
        test_misaligned();
        test_gnt_stall();
        test_flush();
        test_bus_error();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
